// File: rtl/uart_rx_framer.sv
// ============================================================================
// uart_rx_framer : 8N1-style serial receive framer with a valid/ready holding register
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_framer #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial_in,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(DATA_BITS) + 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic [1:0]           r_sync;
  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_ovr;

  logic w_rxs;
  logic w_deliver;

  assign w_rxs     = r_sync[1];
  assign w_deliver = (r_state == S_STOP) && (r_cnt == CNT_LAST) && w_rxs;

  // Framing state machine; cnt restarts from zero on every state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rx_serial_in};
      r_ferr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rxs) r_state <= S_START;
        end
        S_START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= w_rxs ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            // Right shift: after DATA_BITS samples the first bit sits in the LSB.
            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
            r_idx   <= r_idx + IDX_ONE;
            if (r_idx == IDX_LAST) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (w_rxs) begin
              r_state <= S_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_WAIT_HIGH: begin
          r_cnt <= '0;
          if (w_rxs) r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Holding register: a delivery coinciding with a consume replaces the byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_deliver) begin
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data_out = r_data;
  assign rx_valid    = r_valid;
  assign frame_err   = r_ferr;
  assign overrun     = r_ovr;
  assign busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_framer.sv
// ============================================================================
// tb_uart_rx_framer : directed self-checking bench for uart_rx_framer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_framer;

  localparam int CLK_DIV   = 16;
  localparam int DATA_BITS = 8;

  logic       clk;
  logic       rst;
  logic       rx_serial_in;
  logic [7:0] rx_data_out;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_cmp;
  int n_err;

  // Monitor state, written only by the negedge monitor.
  int         cyc;
  int         valid_cycles;
  int         valid_rises;
  int         rise_cyc;
  int         ferr_cnt;
  int         ovr_cnt;
  int         busy_cnt;
  logic       prev_valid;
  logic [7:0] last_data;

  uart_rx_framer #(
    .CLK_DIV  (CLK_DIV),
    .DATA_BITS(DATA_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_serial_in(rx_serial_in),
    .rx_data_out (rx_data_out),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0; valid_cycles = 0; valid_rises = 0; rise_cyc = -1;
    ferr_cnt = 0; ovr_cnt = 0; busy_cnt = 0; prev_valid = 1'b0; last_data = 8'h00;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_valid) begin
      valid_cycles = valid_cycles + 1;
      last_data    = rx_data_out;
      if (!prev_valid) begin
        valid_rises = valid_rises + 1;
        rise_cyc    = cyc;
      end
    end
    prev_valid = rx_valid;
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (overrun)   ovr_cnt  = ovr_cnt + 1;
    if (busy)      busy_cnt = busy_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges, then settle 2 time units past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One frame: start bit, 8 data bits LSB first, stop bit of the given level.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int s);
    s = cyc;
    rx_serial_in = 1'b0;
    tick(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rx_serial_in = b[i];
      tick(CLK_DIV);
    end
    rx_serial_in = stop;
    tick(CLK_DIV);
  endtask

  int s0, s1, b_valid, b_ferr, b_ovr, b_busy, b_rise;

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; rx_serial_in = 1'b1; rx_ready = 1'b0;
    tick(4);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_valid", 32'(rx_valid), 32'd0);
    check_eq("reset_data",  32'(rx_data_out), 32'h00);
    check_eq("reset_busy",  32'(busy), 32'd0);
    check_eq("reset_ferr",  32'(frame_err), 32'd0);
    check_eq("reset_ovr",   32'(overrun), 32'd0);
    tick(3);

    // Single frame 0xA5, consumer always ready: rx_valid rises after edge 154.
    rx_ready = 1'b1;
    b_valid = valid_cycles; b_ferr = ferr_cnt; b_ovr = ovr_cnt; b_rise = valid_rises;
    send_frame(8'hA5, 1'b1, s0);
    tick(20);
    check_eq("a5_rise_time", 32'(rise_cyc - s0), 32'd156);
    check_eq("a5_valid_len", 32'(valid_cycles - b_valid), 32'd1);
    check_eq("a5_data",      32'(last_data), 32'hA5);
    check_eq("a5_ferr",      32'(ferr_cnt - b_ferr), 32'd0);
    check_eq("a5_ovr",       32'(ovr_cnt - b_ovr), 32'd0);

    // Glitch: 4 low cycles, busy from edge 2 until the false-start sample at edge 10.
    b_valid = valid_cycles; b_ferr = ferr_cnt; b_busy = busy_cnt;
    rx_serial_in = 1'b0;
    tick(4);
    rx_serial_in = 1'b1;
    tick(30);
    check_eq("glitch_busy_len", 32'(busy_cnt - b_busy), 32'd8);
    check_eq("glitch_valid",    32'(valid_cycles - b_valid), 32'd0);
    check_eq("glitch_ferr",     32'(ferr_cnt - b_ferr), 32'd0);

    // Break: 0x3C with a low stop bit, line held low, then 0x81.
    b_valid = valid_cycles; b_ferr = ferr_cnt; b_rise = valid_rises;
    send_frame(8'h3C, 1'b0, s0);
    tick(40);
    rx_serial_in = 1'b1;
    tick(20);
    check_eq("break_ferr",  32'(ferr_cnt - b_ferr), 32'd1);
    check_eq("break_valid", 32'(valid_cycles - b_valid), 32'd0);
    send_frame(8'h81, 1'b1, s0);
    tick(20);
    check_eq("after_break_rises", 32'(valid_rises - b_rise), 32'd1);
    check_eq("after_break_data",  32'(last_data), 32'h81);
    check_eq("after_break_ferr",  32'(ferr_cnt - b_ferr), 32'd1);

    // Overrun: consumer stalled, 0x11 then 0x22 back to back.
    rx_ready = 1'b0;
    b_ovr = ovr_cnt; b_ferr = ferr_cnt;
    send_frame(8'h11, 1'b1, s0);
    send_frame(8'h22, 1'b1, s1);
    tick(20);
    @(negedge clk);
    check_eq("ovr_count", 32'(ovr_cnt - b_ovr), 32'd1);
    check_eq("ovr_valid", 32'(rx_valid), 32'd1);
    check_eq("ovr_data",  32'(rx_data_out), 32'h11);
    check_eq("ovr_ferr",  32'(ferr_cnt - b_ferr), 32'd0);
    tick(1);
    rx_ready = 1'b1;
    tick(1);
    @(negedge clk);
    check_eq("consume_clears", 32'(rx_valid), 32'd0);
    tick(1);

    // Replace on delivery: hold 0x11, ready pulses on the 0x22 stop-sample edge.
    rx_ready = 1'b0;
    b_ovr = ovr_cnt;
    send_frame(8'h11, 1'b1, s0);
    tick(3);
    fork
      send_frame(8'h22, 1'b1, s1);
      begin
        tick(154);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    tick(10);
    @(negedge clk);
    check_eq("replace_ovr",   32'(ovr_cnt - b_ovr), 32'd0);
    check_eq("replace_valid", 32'(rx_valid), 32'd1);
    check_eq("replace_data",  32'(rx_data_out), 32'h22);
    tick(1);

    // Reset during data bit 4 of 0xFF while 0x22 is still held.
    b_ferr = ferr_cnt; b_ovr = ovr_cnt;
    fork
      send_frame(8'hFF, 1'b1, s0);
      begin
        tick(86);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_mid_data",  32'(rx_data_out), 32'h00);
        check_eq("rst_mid_busy",  32'(busy), 32'd0);
        check_eq("rst_mid_ferr",  32'(frame_err), 32'd0);
        check_eq("rst_mid_ovr",   32'(overrun), 32'd0);
      end
    join
    tick(20);
    rx_ready = 1'b1;
    b_rise = valid_rises;
    send_frame(8'h5A, 1'b1, s1);
    tick(20);
    check_eq("post_rst_rises", 32'(valid_rises - b_rise), 32'd1);
    check_eq("post_rst_data",  32'(last_data), 32'h5A);
    check_eq("post_rst_ferr",  32'(ferr_cnt - b_ferr), 32'd0);
    check_eq("post_rst_ovr",   32'(ovr_cnt - b_ovr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
